// File: rtl/GF_Divider.sv
// GF_Divider -- combinational GF(2^W) divider.
//   a, b        : field elements (W bits), computes a / b
//   q           : quotient; 0 when b == 0
//   div_by_zero : high when b == 0
// Expects `SYMBOL_WIDTH and `GF_POLY from symbols.v. The fallbacks match
// GF_Multiplier.
`ifndef SYMBOL_WIDTH
  `define SYMBOL_WIDTH 4
`endif
`ifndef GF_POLY
  `define GF_POLY 4'b0011
`endif

module GF_Divider (
  input  logic [`SYMBOL_WIDTH-1:0] a,
  input  logic [`SYMBOL_WIDTH-1:0] b,
  output logic [`SYMBOL_WIDTH-1:0] q,
  output logic                     div_by_zero
);
  localparam int unsigned W = `SYMBOL_WIDTH;
  localparam logic [W-1:0] POLY = `GF_POLY;

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] acc;
    acc = '0;
    for (int unsigned i = W; i > 0; i--) begin
      acc = {acc[W-2:0], 1'b0} ^ (acc[W-1] ? POLY : '0) ^ (y[i-1] ? x : '0);
    end
    return acc;
  endfunction

  // b^-1 = b^(2^W - 2) = b^2 * b^4 * ... * b^(2^(W-1)), built by repeated squaring
  function automatic logic [W-1:0] gf_inv(input logic [W-1:0] x);
    logic [W-1:0] sq;
    logic [W-1:0] inv;
    sq  = x;
    inv = W'(1);
    for (int unsigned k = 1; k < W; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv;
  endfunction

  assign div_by_zero = (b == '0);
  assign q           = div_by_zero ? '0 : gf_mul(a, gf_inv(b));
endmodule

// File: rtl/GF_Multiplier.sv
// GF_Multiplier -- combinational GF(2^W) multiplier.
//   a, b : field elements (W bits)
//   p    : a * b reduced by the field's primitive polynomial
// Expects `SYMBOL_WIDTH, `N and `GF_POLY from symbols.v. The fallback values
// describe GF(16) with x^4 + x + 1. `GF_POLY holds the polynomial without
// its leading x^W term.
`ifndef SYMBOL_WIDTH
  `define SYMBOL_WIDTH 4
`endif
`ifndef N
  `define N 15
`endif
`ifndef GF_POLY
  `define GF_POLY 4'b0011
`endif

module GF_Multiplier (
  input  logic [`SYMBOL_WIDTH-1:0] a,
  input  logic [`SYMBOL_WIDTH-1:0] b,
  output logic [`SYMBOL_WIDTH-1:0] p
);
  localparam int unsigned W = `SYMBOL_WIDTH;
  localparam logic [W-1:0] POLY = `GF_POLY;

  // Horner-style shift-and-add, MSB of y first, reducing on every shift
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] acc;
    acc = '0;
    for (int unsigned i = W; i > 0; i--) begin
      acc = {acc[W-2:0], 1'b0} ^ (acc[W-1] ? POLY : '0) ^ (y[i-1] ? x : '0);
    end
    return acc;
  endfunction

  assign p = gf_mul(a, b);
endmodule

// File: rtl/gf_muldiv_arbiter.sv
// gf_muldiv_arbiter -- two-requester front end sharing one GF multiplier and
// one GF divider.
//   clk, reset           : single clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester request handshake (bit i = requester i)
//   req_op0/1            : 0 = multiply, 1 = divide
//   req_a0/b0, req_a1/b1 : operands; divide computes a / b
//   resp_valid/resp_ready: per-requester result handshake
//   resp_data, resp_err  : shared result and divide-by-zero flag, qualified by resp_valid
//   busy                 : high whenever the FSM is not in IDLE
// Widths come from `SYMBOL_WIDTH in symbols.v.
// Optional macro GF_ARB_ROUND_ROBIN_EN: round-robin arbitration between the two
// requesters. When undefined, requester 0 has fixed priority.
`ifndef SYMBOL_WIDTH
  `define SYMBOL_WIDTH 4
`endif

module gf_muldiv_arbiter (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic                     req_op0,
  input  logic                     req_op1,
  input  logic [`SYMBOL_WIDTH-1:0] req_a0,
  input  logic [`SYMBOL_WIDTH-1:0] req_b0,
  input  logic [`SYMBOL_WIDTH-1:0] req_a1,
  input  logic [`SYMBOL_WIDTH-1:0] req_b1,
  output logic [1:0]               resp_valid,
  input  logic [1:0]               resp_ready,
  output logic [`SYMBOL_WIDTH-1:0] resp_data,
  output logic                     resp_err,
  output logic                     busy
);
  localparam int unsigned W = `SYMBOL_WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic           grant;
  logic           pick;
  logic           cap_op;
  logic [W-1:0]   cap_a;
  logic [W-1:0]   cap_b;
  logic [W-1:0]   mul_p;
  logic [W-1:0]   div_q;
  logic           div_dbz;

`ifdef GF_ARB_ROUND_ROBIN_EN
  logic           last_grant;
`endif

  GF_Multiplier u_mul (
    .a (cap_a),
    .b (cap_b),
    .p (mul_p)
  );

  GF_Divider u_div (
    .a           (cap_a),
    .b           (cap_b),
    .q           (div_q),
    .div_by_zero (div_dbz)
  );

  // Only contention needs a policy; a lone requester always wins
  always_comb begin
`ifdef GF_ARB_ROUND_ROBIN_EN
    pick = (req_valid == 2'b11) ? ~last_grant : ~req_valid[0];
`else
    pick = ~req_valid[0];
`endif
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && req_valid != 2'b00) begin
      req_ready[pick] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      cap_op     <= 1'b0;
      cap_a      <= '0;
      cap_b      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
`ifdef GF_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            grant  <= pick;
            cap_op <= pick ? req_op1 : req_op0;
            cap_a  <= pick ? req_a1  : req_a0;
            cap_b  <= pick ? req_b1  : req_b0;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= cap_op ? div_q : mul_p;
          resp_err   <= cap_op & div_dbz;
          resp_valid <= grant ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          // The handshake cycle returns to IDLE without accepting; the next
          // request is taken one cycle later, giving a 3-cycle op period
          if (resp_ready[grant]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef GF_ARB_ROUND_ROBIN_EN
            last_grant <= grant;
`endif
          end
        end
        default: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/gf_muldiv_arbiter.md
GF_MULDIV_ARBITER -- requirements
Module: gf_muldiv_arbiter

Interface
REQ-001 Parameters: none; `SYMBOL_WIDTH (symbol width, W) and `N (field order minus one) SHALL come from symbols.v.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  out  2  per-requester request accept.
REQ-006 req_op0, req_op1  in  1 each  operation: 0 = multiply, 1 = divide.
REQ-007 req_a0, req_b0, req_a1, req_b1  in  W each  operands; divide computes a / b.
REQ-008 resp_valid  out  2  per-requester result valid.
REQ-009 resp_ready  in  2  per-requester result accept.
REQ-010 resp_data  out  W  result, shared by both requesters, qualified by resp_valid.
REQ-011 resp_err  out  1  divide-by-zero flag, qualified by resp_valid.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL contain exactly one GF_Multiplier and one GF_Divider instance, both fed from captured operand registers.
REQ-014 FSM states SHALL be IDLE, EXEC and RESP.
REQ-015 In IDLE, with at least one req_valid bit high, the block SHALL pick one requester by arbitration, drive that requester's req_ready high combinationally in the same cycle, capture its op/a/b and grant index, and go to EXEC.
REQ-016 req_ready SHALL be zero outside IDLE, and for any requester not granted.
REQ-017 In EXEC the block SHALL register the multiplier or divider output into resp_data, set resp_err, and go to RESP.
REQ-018 In RESP, resp_valid[grant] SHALL be high and resp_data/resp_err SHALL be held stable until resp_ready[grant] is high.
REQ-019 On the resp handshake the block SHALL return to IDLE and update the arbitration pointer; the response handshake cycle SHALL NOT also accept a new request.
REQ-020 Latency: accept in cycle t gives resp_valid in cycle t+2; with resp_ready held high, back-to-back ops SHALL complete every 3 cycles.
REQ-021 resp_ready bits for the non-granted requester SHALL be ignored.
REQ-022 Divide with captured b == 0 SHALL give resp_err = 1 and resp_data = 0.
REQ-023 A multiply SHALL give resp_err = 0 for every input; in particular a = 0 SHALL give resp_data = 0.
REQ-024 A request whose req_valid drops before acceptance SHALL be dropped with no side effect.

Reset
REQ-025 While reset is high at a clock edge, the FSM SHALL go to IDLE and the outputs SHALL reset to: resp_valid = 0, resp_data = 0, resp_err = 0, busy = 0, and the arbitration pointer to "last grant = 1".
REQ-026 Reset in EXEC or RESP SHALL abandon the in-flight operation; no response SHALL be produced for it.

Configuration
REQ-027 With GF_ARB_ROUND_ROBIN_EN defined, requester 0 SHALL win when the pointer shows last grant = 1, requester 1 SHALL win when it shows last grant = 0, and the pointer SHALL update only on the resp handshake.
REQ-028 With GF_ARB_ROUND_ROBIN_EN undefined, requester 0 SHALL always win over requester 1 (fixed priority), and the pointer logic SHALL be absent.

Verification
REQ-029 Reset mid-op: accept a multiply, assert reset in the EXEC cycle -> next cycle busy = 0 and resp_valid = 00, and no response ever appears for that op.
REQ-030 Single multiply: req_valid = 01, op = 0, a = 0, b = 5 -> req_ready = 01 in cycle t, resp_valid = 01 in cycle t+2, resp_data = 0, resp_err = 0.
REQ-031 Divide by zero: requester 1, op = 1, a = 7, b = 0 -> resp_valid = 10 at t+2, resp_err = 1, resp_data = 0.
REQ-032 Contention with round robin enabled, both valid continuously, resp_ready = 11 -> grant order 0, 1, 0, 1, with acceptances 3 cycles apart.
REQ-033 Contention with round robin disabled, same stimulus -> requester 0 granted every time and requester 1 never granted.
REQ-034 Back-pressure: resp_ready = 00 for 10 cycles in RESP -> resp_valid, resp_data and resp_err stay stable, req_ready = 00 and busy = 1 throughout.
